hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the five-stage core. Drives per-stage enable and flush strobes for the PC, IF/ID, ID/EX and EX/MEM registers. Covers the post-reset fetch bubble, load-use stalls, branch/jump redirects, instruction-memory wait states and multi-cycle MDU (mul/div) operations. Sits beside the datapath; every pipeline register consumes its `*_en_o` / `*_flush_o` pair.

## Interface
- `BOOT_CYCLES`, default 1: bubble cycles after reset release; legal range 1..15.
- `MDU_TIMEOUT`, default 64: maximum cycles spent in MDU_WAIT before forced release; legal range 2..255.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_ni` in 1: reset; one clock, asynchronous assert, active-low.
- `id_rs1_i` in 5: source register 1 of the instruction in ID.
- `id_rs2_i` in 5: source register 2 of the instruction in ID.
- `id_use_rs1_i` in 1: the ID instruction reads rs1.
- `id_use_rs2_i` in 1: the ID instruction reads rs2.
- `ex_rd_i` in 5: destination register of the instruction in EX.
- `ex_is_load_i` in 1: the EX instruction is a load.
- `redirect_i` in 1: EX resolved a taken branch or jump; PC mux selects the target this cycle.
- `mdu_start_i` in 1: EX holds a valid multi-cycle MDU operation (first cycle).
- `mdu_done_i` in 1: MDU result valid this cycle.
- `imem_ready_i` in 1: fetch data valid this cycle.
- `pc_en_o` out 1: PC register load enable.
- `ifid_en_o` out 1: IF/ID register load enable.
- `ifid_flush_o` out 1: load a NOP/zero into IF/ID; wins over enable.
- `idex_en_o` out 1: ID/EX register load enable.
- `idex_flush_o` out 1: load a bubble into ID/EX; wins over enable.
- `exmem_flush_o` out 1: load a bubble into EX/MEM.
- `mdu_err_o` out 1: sticky MDU timeout flag.
- `stall_cnt_o` out 16: saturating count of stalled cycles.

## Operation
The FSM has three states: BOOT, RUN and MDU_WAIT. Registered state consists of the FSM state, a 4-bit boot counter, an 8-bit MDU counter, `mdu_err_o` and `stall_cnt_o`. All strobes are combinational from the state and the current inputs.

"Default" strobe values: all `*_en_o`=1 and all `*_flush_o`=0.

**BOOT** (entered on reset)
- Strobes: `pc_en_o`=0, `ifid_en_o`=1, `ifid_flush_o`=1, `idex_flush_o`=1, `exmem_flush_o`=1.
- The boot counter increments each cycle; the FSM moves to RUN after `BOOT_CYCLES` cycles.

**RUN**: conditions are evaluated in priority order; the first match sets the strobes.
1. `redirect_i`: `pc_en_o`=1, `ifid_flush_o`=1, `idex_flush_o`=1, everything else default.
   - A simultaneous `mdu_start_i` is ignored; the FSM stays in RUN.
2. `mdu_start_i`: `pc_en_o`=0, `ifid_en_o`=0, `idex_en_o`=0, `exmem_flush_o`=1.
   - Next state MDU_WAIT; the MDU counter clears to 1.
3. Load-use: `ex_is_load_i` && `ex_rd_i`≠0 && ((`id_use_rs1_i` && rs1==rd) || (`id_use_rs2_i` && rs2==rd)).
   - Strobes: `pc_en_o`=0, `ifid_en_o`=0, `idex_flush_o`=1.
   - Lasts exactly one cycle, because the load advances out of EX.
4. `!imem_ready_i`: `pc_en_o`=0, `ifid_flush_o`=1, ID/EX default.
5. Otherwise: default strobes.

**MDU_WAIT**
- Strobes: `pc_en_o`=0, `ifid_en_o`=0, `idex_en_o`=0, `exmem_flush_o`=1; the MDU counter increments.
- `mdu_done_i`, or counter == `MDU_TIMEOUT`: default strobes for that cycle, next state RUN.
- A timeout sets `mdu_err_o`=1. The flag clears only on reset.
- `redirect_i` and `mdu_start_i` are ignored in this state.

**Stall counter**
- `stall_cnt_o` increments in any RUN or MDU_WAIT cycle where `pc_en_o`=0.
- It saturates at 16'hFFFF and is cleared only by reset.

## Timing
- **Reset**: `rst_ni` low puts the FSM in BOOT immediately and asynchronously, with both counters at 0, `mdu_err_o`=0 and `stall_cnt_o`=0.
  - Outputs during reset equal the BOOT strobes.
  - Reset asserted mid-MDU_WAIT abandons the operation; no error is flagged.
- **First PC advance**: first edge with `pc_en_o`=1 is the edge that ends cycle `BOOT_CYCLES`+1 after the first `rst_ni` rising edge sampled high.
- **Strobe latency**: zero-cycle combinational path from `redirect_i`, hazard inputs and `imem_ready_i` to the strobes.
- **MDU latency**: an operation completing N cycles after start stalls the front end for N cycles, counting the start cycle. The done cycle releases the stall.
- **Simultaneous events**:
  - `redirect_i` with a load-use hazard or `!imem_ready_i`: redirect wins.
  - Load-use with `!imem_ready_i`: load-use wins.

## Structure
- Shared package `core_pkg` holds:
  - the FSM state enum `hz_state_e` (BOOT, RUN, MDU_WAIT);
  - `REG_ZERO` = 5'd0;
  - the strobe bundle field ordering.
- Natural sub-module: `hazard_detect`, the combinational load-use comparator, reusable by the forwarding unit.
- The FSM and counters stay in `hazard_ctrl`.

## Test plan
- **Reset/boot**: release `rst_ni` with `BOOT_CYCLES`=1.
  - Cycle 1: `pc_en_o`=0, `ifid_flush_o`=1.
  - Cycle 2: all defaults; `stall_cnt_o`=0.
- **Load-use on rs2**: `ex_is_load_i`=1, `ex_rd_i`=5, `id_rs2_i`=5, `id_use_rs2_i`=1.
  - Expect exactly one cycle of `pc_en_o`=0, `ifid_en_o`=0, `idex_flush_o`=1.
  - Repeat with `ex_rd_i`=0: expect no stall.
- **Redirect with load-use in the same cycle** → `pc_en_o`=1, `ifid_flush_o`=1, `idex_flush_o`=1.
- **MDU**: `mdu_start_i` pulse, `mdu_done_i` 4 cycles later.
  - Expect 4 stalled cycles, then release on the done cycle.
  - `stall_cnt_o` has increased by 4.
- **MDU timeout**: `MDU_TIMEOUT`=8, `mdu_done_i` never asserted.
  - Release on the 8th MDU_WAIT cycle; `mdu_err_o`=1 and stays set until reset.
- **Reset mid-MDU_WAIT**:
  - Outputs go to the BOOT values asynchronously.
  - `mdu_err_o`=0 and `stall_cnt_o`=0.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg
// Shared types for the core's pipeline control logic.
//   hz_state_e : sequencing FSM states (BOOT, RUN, MDU_WAIT)
//   REG_ZERO   : architectural zero register index
//   strobe_t   : per-stage enable/flush bundle; the field order is fixed
//                and is reused by anything that packs or unpacks strobes.
package core_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MDU_WAIT = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Field order, MSB first: pc_en, ifid_en, ifid_flush, idex_en,
  // idex_flush, exmem_flush.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_flush;
  } strobe_t;

  localparam strobe_t STROBE_DEFAULT = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                         idex_en: 1'b1, idex_flush: 1'b0, exmem_flush: 1'b0};
  // Post-reset bubble: hold PC, drain everything behind it.
  localparam strobe_t STROBE_BOOT = '{pc_en: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b1,
                                      idex_en: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1};
  // Taken branch/jump: PC loads the target, kill the two younger stages.
  localparam strobe_t STROBE_REDIRECT = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                          idex_en: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b0};
  // MDU busy: freeze the front end, keep EX from retiring a bogus result.
  localparam strobe_t STROBE_MDU = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                     idex_en: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b1};
  // Load-use: hold IF/ID, insert a bubble into EX while the load moves on.
  localparam strobe_t STROBE_LOAD_USE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                          idex_en: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b0};
  // Fetch wait state: hold PC, feed a NOP into ID, back end flows freely.
  localparam strobe_t STROBE_IMEM = '{pc_en: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b1,
                                      idex_en: 1'b1, idex_flush: 1'b0, exmem_flush: 1'b0};

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
// Bundle between the datapath and the pipeline sequencing controller.
//   Hazard/event inputs : id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
//                         ex_rd_i, ex_is_load_i, redirect_i, mdu_start_i,
//                         mdu_done_i, imem_ready_i
//   Strobe outputs      : pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o,
//                         idex_flush_o, exmem_flush_o
//   Status outputs      : mdu_err_o, stall_cnt_o, dbg_state (FSM state)
// Handshake: there is no valid/ready pair. Inputs are level signals that
// describe the current cycle; the controller answers combinationally in
// the same cycle and every pipeline register samples the strobes on the
// next rising clock edge.
// Modports: master = datapath side, slave = hazard_ctrl side.
interface hazard_ctrl_if;
  import core_pkg::*;

  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_use_rs1_i;
  logic        id_use_rs2_i;
  logic [4:0]  ex_rd_i;
  logic        ex_is_load_i;
  logic        redirect_i;
  logic        mdu_start_i;
  logic        mdu_done_i;
  logic        imem_ready_i;

  logic        pc_en_o;
  logic        ifid_en_o;
  logic        ifid_flush_o;
  logic        idex_en_o;
  logic        idex_flush_o;
  logic        exmem_flush_o;
  logic        mdu_err_o;
  logic [15:0] stall_cnt_o;
  hz_state_e   dbg_state;

  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_rd_i, ex_is_load_i,
           redirect_i, mdu_start_i, mdu_done_i, imem_ready_i,
    input  pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o, exmem_flush_o,
           mdu_err_o, stall_cnt_o, dbg_state
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_rd_i, ex_is_load_i,
           redirect_i, mdu_start_i, mdu_done_i, imem_ready_i,
    output pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o, exmem_flush_o,
           mdu_err_o, stall_cnt_o, dbg_state
  );

endinterface

// File: rtl/hazard_detect.sv
// hazard_detect
// Combinational load-use comparator. Flags when the instruction in ID
// reads a register that a load currently in EX will write. Writes to x0
// are never a hazard. Kept standalone so the forwarding unit can reuse it.
//   rs1, rs2         : source registers of the ID instruction
//   use_rs1, use_rs2 : ID instruction actually reads that source
//   rd               : destination of the EX instruction
//   is_load          : EX instruction is a load
//   load_use         : stall required this cycle
module hazard_detect
  import core_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic [4:0] rd,
  input  logic       is_load,
  output logic       load_use
);

  logic match_rs1;
  logic match_rs2;

  assign match_rs1 = use_rs1 && (rs1 == rd);
  assign match_rs2 = use_rs2 && (rs2 == rd);
  assign load_use  = is_load && (rd != REG_ZERO) && (match_rs1 || match_rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline sequencing controller for the five-stage core. Produces the
// enable/flush strobes for PC, IF/ID, ID/EX and EX/MEM from a small FSM
// (BOOT -> RUN <-> MDU_WAIT) and the current-cycle hazard inputs.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : hazard_ctrl_if.slave (hazard inputs, strobes, status, FSM state)
// Parameters:
//   BOOT_CYCLES : bubble cycles after reset release (1..15)
//   MDU_TIMEOUT : max MDU_WAIT cycles before forced release (2..255)
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 1,
  parameter int unsigned MDU_TIMEOUT = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  hazard_ctrl_if.slave bus
);

  localparam logic [3:0] BOOT_LAST   = 4'(BOOT_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_CNT = 8'(MDU_TIMEOUT);

  hz_state_e   state_q;
  hz_state_e   state_d;
  logic [3:0]  boot_cnt_q;
  logic [7:0]  mdu_cnt_q;
  logic        mdu_err_q;
  logic [15:0] stall_cnt_q;

  strobe_t     strb;
  logic        load_use;
  logic        mdu_timeout;

  hazard_detect u_detect (
    .rs1      (bus.id_rs1_i),
    .rs2      (bus.id_rs2_i),
    .use_rs1  (bus.id_use_rs1_i),
    .use_rs2  (bus.id_use_rs2_i),
    .rd       (bus.ex_rd_i),
    .is_load  (bus.ex_is_load_i),
    .load_use (load_use)
  );

  // Strobes and next state. RUN evaluates events in strict priority:
  // redirect, MDU start, load-use, fetch wait.
  always_comb begin
    strb        = STROBE_DEFAULT;
    state_d     = state_q;
    mdu_timeout = 1'b0;
    case (state_q)
      BOOT: begin
        strb = STROBE_BOOT;
        if (boot_cnt_q == BOOT_LAST) state_d = RUN;
      end
      RUN: begin
        if (bus.redirect_i) begin
          // A start on the wrong path is squashed along with it.
          strb = STROBE_REDIRECT;
        end else if (bus.mdu_start_i) begin
          strb    = STROBE_MDU;
          state_d = MDU_WAIT;
        end else if (load_use) begin
          strb = STROBE_LOAD_USE;
        end else if (!bus.imem_ready_i) begin
          strb = STROBE_IMEM;
        end
      end
      MDU_WAIT: begin
        // The release cycle runs with default strobes so the result
        // moves into EX/MEM and the front end resumes on the same edge.
        if (bus.mdu_done_i) begin
          state_d = RUN;
        end else if (mdu_cnt_q == TIMEOUT_CNT) begin
          state_d     = RUN;
          mdu_timeout = 1'b1;
        end else begin
          strb = STROBE_MDU;
        end
      end
      default: begin
        strb    = STROBE_BOOT;
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= BOOT;
      boot_cnt_q  <= 4'd0;
      mdu_cnt_q   <= 8'd0;
      mdu_err_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;

      if (state_q == BOOT) boot_cnt_q <= boot_cnt_q + 4'd1;

      // Counter reads 1 during the first MDU_WAIT cycle, so reaching
      // MDU_TIMEOUT means that many cycles have been spent waiting.
      if (state_q == RUN && state_d == MDU_WAIT) begin
        mdu_cnt_q <= 8'd1;
      end else if (state_q == MDU_WAIT) begin
        mdu_cnt_q <= mdu_cnt_q + 8'd1;
      end

      if (mdu_timeout) mdu_err_q <= 1'b1;

      // Boot bubbles are not stalls; only held PCs in RUN/MDU_WAIT count.
      if (state_q != BOOT && !strb.pc_en && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign bus.pc_en_o       = strb.pc_en;
  assign bus.ifid_en_o     = strb.ifid_en;
  assign bus.ifid_flush_o  = strb.ifid_flush;
  assign bus.idex_en_o     = strb.idex_en;
  assign bus.idex_flush_o  = strb.idex_flush;
  assign bus.exmem_flush_o = strb.exmem_flush;
  assign bus.mdu_err_o     = mdu_err_q;
  assign bus.stall_cnt_o   = stall_cnt_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed bench for hazard_ctrl (BOOT_CYCLES=1, MDU_TIMEOUT=8). The
// driver sets each cycle's inputs and pushes the hand-computed response
// {strobes, mdu_err, stall_cnt} onto exp_q; the monitor pops one entry per
// falling edge and compares it against the live outputs.
module tb_hazard_ctrl;
  import core_pkg::*;

  localparam int W = 23;

  // Strobe order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush
  localparam logic [5:0] S_DEF   = 6'b110100;
  localparam logic [5:0] S_BOOT  = 6'b011111;
  localparam logic [5:0] S_REDIR = 6'b111110;
  localparam logic [5:0] S_MDU   = 6'b000001;
  localparam logic [5:0] S_LU    = 6'b000110;
  localparam logic [5:0] S_IMEM  = 6'b011100;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_ni;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if bus ();

  hazard_ctrl #(
    .BOOT_CYCLES (1),
    .MDU_TIMEOUT (8)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp;
  int           n_err;

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    string        nm;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {bus.pc_en_o, bus.ifid_en_o, bus.ifid_flush_o, bus.idex_en_o,
             bus.idex_flush_o, bus.exmem_flush_o, bus.mdu_err_o, bus.stall_cnt_o};
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got strobes=%b err=%b stall=%0d, expected strobes=%b err=%b stall=%0d",
                 nm, act[22:17], act[16], act[15:0], e[22:17], e[16], e[15:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_out(input logic [5:0] s, input logic err, input logic [15:0] sc,
                            input string nm);
    exp_q.push_back({s, err, sc});
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic ld,
                       input logic redir, input logic ms, input logic md, input logic imr);
    bus.id_rs1_i     = rs1;
    bus.id_rs2_i     = rs2;
    bus.id_use_rs1_i = u1;
    bus.id_use_rs2_i = u2;
    bus.ex_rd_i      = rd;
    bus.ex_is_load_i = ld;
    bus.redirect_i   = redir;
    bus.mdu_start_i  = ms;
    bus.mdu_done_i   = md;
    bus.imem_ready_i = imr;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic release_reset();
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_ni = 1'b0;
    idle();
    #2;
    expect_out(S_BOOT, 1'b0, 16'd0, "in_reset");

    // Boot bubble with BOOT_CYCLES=1.
    release_reset();
    expect_out(S_BOOT, 1'b0, 16'd0, "boot_c1");                    tick();
    expect_out(S_DEF, 1'b0, 16'd0, "boot_c2");                     tick();

    // Load-use on rs2, one cycle only.
    drive(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(S_LU, 1'b0, 16'd0, "lu_rs2");                       tick();
    idle();
    expect_out(S_DEF, 1'b0, 16'd1, "lu_release");                  tick();
    // Load to x0: no hazard.
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(S_DEF, 1'b0, 16'd1, "lu_rd0");                      tick();
    // Load-use on rs1.
    drive(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(S_LU, 1'b0, 16'd1, "lu_rs1");                       tick();
    // Register matches but the source is not read.
    drive(5'd7, 5'd9, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(S_DEF, 1'b0, 16'd2, "lu_nouse");                    tick();

    // Redirect beats load-use, and squashes an MDU start.
    drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out(S_REDIR, 1'b0, 16'd2, "redir_lu");                  tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    expect_out(S_REDIR, 1'b0, 16'd2, "redir_mdu");                 tick();

    // Fetch wait state, then load-use beating it.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(S_IMEM, 1'b0, 16'd2, "imem_wait");                  tick();
    drive(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(S_LU, 1'b0, 16'd3, "lu_imem");                      tick();
    idle();
    expect_out(S_DEF, 1'b0, 16'd4, "idle");                        tick();

    // MDU completing 4 cycles after start; redirect ignored while waiting.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_out(S_MDU, 1'b0, 16'd4, "mdu_start");                   tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out(S_MDU, 1'b0, 16'd5, "mdu_w1_redir");                tick();
    idle();
    expect_out(S_MDU, 1'b0, 16'd6, "mdu_w2");                      tick();
    expect_out(S_MDU, 1'b0, 16'd7, "mdu_w3");                      tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_out(S_DEF, 1'b0, 16'd8, "mdu_done");                    tick();
    idle();
    expect_out(S_DEF, 1'b0, 16'd8, "mdu_after");                   tick();

    // MDU timeout: done never comes, release on the 8th MDU_WAIT cycle.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_out(S_MDU, 1'b0, 16'd8, "to_start");                    tick();
    idle();
    for (int i = 1; i <= 7; i++) begin
      expect_out(S_MDU, 1'b0, 16'(8 + i), $sformatf("to_wait%0d", i));
      tick();
    end
    expect_out(S_DEF, 1'b0, 16'd16, "to_release");                 tick();
    expect_out(S_DEF, 1'b1, 16'd16, "err_set");                    tick();
    drive(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(S_LU, 1'b1, 16'd16, "err_sticky_lu");               tick();

    // Reset asserted mid-MDU_WAIT, between clock edges.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_out(S_MDU, 1'b1, 16'd17, "rst_pre_start");              tick();
    idle();
    expect_out(S_MDU, 1'b1, 16'd18, "rst_pre_wait");               tick();
    #2;
    rst_ni = 1'b0;
    expect_out(S_BOOT, 1'b0, 16'd0, "rst_async");                  tick();
    expect_out(S_BOOT, 1'b0, 16'd0, "rst_hold");
    release_reset();
    expect_out(S_BOOT, 1'b0, 16'd0, "reboot_c1");                  tick();
    expect_out(S_DEF, 1'b0, 16'd0, "reboot_c2");                   tick();

    // Let the monitor drain, bounded.
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
